dcache_store_responder: RTL and testbench

//  Responder end of the D$ store-port and AMO interfaces. Accepts two-phase store requests
//  (index+data, then tag) and AMO requests, and executes them on a single-port 64-bit

---
 rtl/dcache_store_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dcache_store_responder.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_store_responder.sv
// D$ store-port / AMO responder on a single-port 64-bit data memory.
// Optional perf counters: define STRESP_PERF_CNT_EN.
module dcache_store_responder #(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned INDEX_W = 12,
  parameter int unsigned MEM_AW  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_req_i,
  input  logic [INDEX_W-1:0]      st_index_i,
  input  logic [63:0]             st_wdata_i,
  input  logic [7:0]              st_be_i,
  output logic                    st_gnt_o,
  input  logic                    st_tag_valid_i,
  input  logic [PLEN-INDEX_W-1:0] st_tag_i,
  input  logic                    st_kill_i,
  input  logic                    amo_req_i,
  input  logic [3:0]              amo_op_i,
  input  logic [1:0]              amo_size_i,
  input  logic [PLEN-1:0]         amo_addr_i,
  input  logic [63:0]             amo_operand_i,
  output logic                    amo_ack_o,
  output logic [63:0]             amo_result_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  output logic [63:0]             mem_wdata_o,
  output logic [7:0]              mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [63:0]             mem_rdata_i,
  output logic [31:0]             perf_st_cnt_o,
  output logic [31:0]             perf_amo_cnt_o
);

  localparam logic [3:0] AMO_LR   = 4'h1;
  localparam logic [3:0] AMO_SC   = 4'h2;
  localparam logic [3:0] AMO_SWAP = 4'h3;
  localparam logic [3:0] AMO_ADD  = 4'h4;
  localparam logic [3:0] AMO_AND  = 4'h5;
  localparam logic [3:0] AMO_OR   = 4'h6;
  localparam logic [3:0] AMO_XOR  = 4'h7;
  localparam logic [3:0] AMO_MAX  = 4'h8;
  localparam logic [3:0] AMO_MAXU = 4'h9;
  localparam logic [3:0] AMO_MIN  = 4'hA;
  localparam logic [3:0] AMO_MINU = 4'hB;

  typedef enum logic [2:0] {
    IDLE, ST_TAG, ST_WRITE,
    AMO_RD, AMO_WAIT, AMO_WR, AMO_RESP
  } state_e;

  state_e state_q, state_d;

  logic [INDEX_W-1:3] idx_q;
  logic [63:0]        sdata_q;
  logic [7:0]         sbe_q;
  logic [MEM_AW-1:0]  swaddr_q;
  logic [3:0]         op_q;
  logic               word_q;
  logic [PLEN-1:2]    aaddr_q;
  logic [63:0]        opnd_q;
  logic [63:0]        old_q;
  logic [63:0]        res_q;
  logic               resv_v_q;
  logic [PLEN-1:3]    resv_q;
  logic               guard_q;

  logic [PLEN-1:3] st_waddr;
  logic            st_commit;
  logic            amo_start;
  logic            op_known;
  logic            sc_ok;
  logic            lane;
  logic [31:0]     rd_word;
  logic [63:0]     rd_ext;
  logic            unused_addr;

  assign unused_addr = ^{st_index_i[2:0], amo_addr_i[1:0]};

  assign st_waddr  = {st_tag_i, idx_q};
  assign st_commit = st_tag_valid_i & ~st_kill_i;
  assign amo_start = amo_req_i & ~st_req_i & ~guard_q;
  assign op_known  = (amo_op_i != 4'h0) &&
                     (amo_op_i <= AMO_MINU);
  assign sc_ok     = resv_v_q &&
                     (resv_q == aaddr_q[PLEN-1:3]);
  assign lane      = aaddr_q[2];
  assign rd_word   = lane ? mem_rdata_i[63:32]
                          : mem_rdata_i[31:0];
  assign rd_ext    = word_q ? {{32{rd_word[31]}}, rd_word}
                            : mem_rdata_i;

  // Word ops are widened to 64 bits so one ALU serves both sizes
  logic [31:0] o32;
  logic [63:0] a_s, b_s, a_u, b_u, new_v;
  logic [63:0] amo_wdata;
  logic [7:0]  amo_be;
  logic        lt_s, lt_u;

  assign o32 = lane ? old_q[63:32] : old_q[31:0];
  assign a_s = word_q ? {{32{o32[31]}}, o32} : old_q;
  assign b_s = word_q ? {{32{opnd_q[31]}}, opnd_q[31:0]}
                      : opnd_q;
  assign a_u = word_q ? {32'h0, o32} : old_q;
  assign b_u = word_q ? {32'h0, opnd_q[31:0]} : opnd_q;
  assign lt_s = $signed(a_s) < $signed(b_s);
  assign lt_u = a_u < b_u;

  always_comb begin
    new_v = b_s;
    unique case (op_q)
      AMO_ADD:  new_v = a_s + b_s;
      AMO_AND:  new_v = a_s & b_s;
      AMO_OR:   new_v = a_s | b_s;
      AMO_XOR:  new_v = a_s ^ b_s;
      AMO_MAX:  new_v = lt_s ? b_s : a_s;
      AMO_MAXU: new_v = lt_u ? b_u : a_u;
      AMO_MIN:  new_v = lt_s ? a_s : b_s;
      AMO_MINU: new_v = lt_u ? a_u : b_u;
      default:  new_v = b_s;
    endcase
  end

  assign amo_wdata = word_q ? {new_v[31:0], new_v[31:0]}
                            : new_v;
  assign amo_be    = word_q ? (lane ? 8'hF0 : 8'h0F)
                            : 8'hFF;

  always_comb begin
    state_d     = state_q;
    st_gnt_o    = 1'b0;
    amo_ack_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    unique case (state_q)
      IDLE: begin
        st_gnt_o = st_req_i;
        if (st_req_i)
          state_d = ST_TAG;
        else if (amo_start)
          state_d = op_known ? AMO_RD : AMO_RESP;
      end
      ST_TAG: begin
        state_d = st_commit ? ST_WRITE : IDLE;
      end
      ST_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = swaddr_q;
        mem_wdata_o = sdata_q;
        mem_be_o    = sbe_q;
        if (mem_gnt_i) state_d = IDLE;
      end
      AMO_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = aaddr_q[MEM_AW+2:3];
        if (mem_gnt_i) state_d = AMO_WAIT;
      end
      AMO_WAIT: begin
        if (mem_rvalid_i) begin
          if (op_q == AMO_LR)
            state_d = AMO_RESP;
          else if (op_q == AMO_SC)
            state_d = sc_ok ? AMO_WR : AMO_RESP;
          else
            state_d = AMO_WR;
        end
      end
      AMO_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = aaddr_q[MEM_AW+2:3];
        mem_wdata_o = amo_wdata;
        mem_be_o    = amo_be;
        if (mem_gnt_i) state_d = AMO_RESP;
      end
      AMO_RESP: begin
        amo_ack_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sdata_q  <= '0;
      sbe_q    <= '0;
      swaddr_q <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      aaddr_q  <= '0;
      opnd_q   <= '0;
      old_q    <= '0;
      res_q    <= '0;
      resv_v_q <= 1'b0;
      resv_q   <= '0;
      guard_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Keeps a still-high amo_req_i from re-executing right after ack
      guard_q <= (state_q == AMO_RESP);
      if (state_q == IDLE && st_req_i) begin
        idx_q   <= st_index_i[INDEX_W-1:3];
        sdata_q <= st_wdata_i;
        sbe_q   <= st_be_i;
      end else if (state_q == IDLE && amo_start) begin
        op_q    <= amo_op_i;
        word_q  <= (amo_size_i == 2'b10);
        aaddr_q <= amo_addr_i[PLEN-1:2];
        opnd_q  <= amo_operand_i;
        res_q   <= '0;
      end
      if (state_q == ST_TAG && st_commit) begin
        swaddr_q <= st_waddr[MEM_AW+2:3];
        if (resv_q == st_waddr) resv_v_q <= 1'b0;
      end
      if (state_q == AMO_WAIT && mem_rvalid_i) begin
        old_q <= mem_rdata_i;
        if (op_q == AMO_SC) begin
          resv_v_q <= 1'b0;
          res_q    <= sc_ok ? 64'd0 : 64'd1;
        end else begin
          res_q <= rd_ext;
          if (op_q == AMO_LR) begin
            resv_v_q <= 1'b1;
            resv_q   <= aaddr_q[PLEN-1:3];
          end
        end
      end
    end
  end

`ifdef STRESP_PERF_CNT_EN
  logic [31:0] st_cnt_q, amo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_cnt_q  <= '0;
      amo_cnt_q <= '0;
    end else begin
      if (state_q == ST_WRITE && mem_gnt_i)
        st_cnt_q <= st_cnt_q + 32'd1;
      if (amo_ack_o)
        amo_cnt_q <= amo_cnt_q + 32'd1;
    end
  end

  assign perf_st_cnt_o  = st_cnt_q;
  assign perf_amo_cnt_o = amo_cnt_q;
`else
  assign perf_st_cnt_o  = '0;
  assign perf_amo_cnt_o = '0;
`endif

  assign amo_result_o = res_q;

endmodule

// File: tb/tb_dcache_store_responder.sv
// Scoreboard bench for dcache_store_responder with a
// random-latency memory and a reference memory/reservation model.
module tb_dcache_store_responder;

  localparam int PLEN    = 56;
  localparam int INDEX_W = 12;
  localparam int MEM_AW  = 16;

  localparam logic [3:0] LR   = 4'h1;
  localparam logic [3:0] SC   = 4'h2;
  localparam logic [3:0] SWAP = 4'h3;
  localparam logic [3:0] ADD  = 4'h4;
  localparam logic [3:0] MIN  = 4'hA;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    st_req, st_gnt;
  logic [INDEX_W-1:0]      st_index;
  logic [63:0]             st_wdata;
  logic [7:0]              st_be;
  logic                    st_tag_valid, st_kill;
  logic [PLEN-INDEX_W-1:0] st_tag;
  logic                    amo_req, amo_ack;
  logic [3:0]              amo_op;
  logic [1:0]              amo_size;
  logic [PLEN-1:0]         amo_addr;
  logic [63:0]             amo_operand, amo_result;
  logic                    mem_req, mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [63:0]             mem_wdata, mem_rdata;
  logic [7:0]              mem_be;
  logic                    mem_gnt, mem_rvalid;
  logic [31:0]             perf_st, perf_amo;

  dcache_store_responder #(
    .PLEN(PLEN), .INDEX_W(INDEX_W), .MEM_AW(MEM_AW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .st_req_i(st_req), .st_index_i(st_index),
    .st_wdata_i(st_wdata), .st_be_i(st_be),
    .st_gnt_o(st_gnt), .st_tag_valid_i(st_tag_valid),
    .st_tag_i(st_tag), .st_kill_i(st_kill),
    .amo_req_i(amo_req), .amo_op_i(amo_op),
    .amo_size_i(amo_size), .amo_addr_i(amo_addr),
    .amo_operand_i(amo_operand), .amo_ack_o(amo_ack),
    .amo_result_o(amo_result),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .perf_st_cnt_o(perf_st), .perf_amo_cnt_o(perf_amo)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t         exp_wr[$];
  logic [63:0] exp_res[$];
  logic [63:0] mem     [0:65535];
  logic [63:0] ref_mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          resv_v;
  logic [52:0] resv_a;
  int          exp_st_cnt, exp_amo_cnt;
  logic [63:0] last_res;
  logic [63:0] rd_pend;
  int          rv_cnt;

  function automatic logic [63:0] bmask(input logic [7:0] b);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] w,
                         input logic [63:0] v);
    mem[w]     = v;
    ref_mem[w] = v;
  endtask

  // Reference model: memory image, reservation, counters
  task automatic ref_store(input logic [55:0] pa,
                           input logic [63:0] d,
                           input logic [7:0]  b);
    logic [15:0] w;
    logic [63:0] m;
    w = pa[18:3];
    m = bmask(b);
    ref_mem[w] = (ref_mem[w] & ~m) | (d & m);
    if (resv_v && resv_a == pa[55:3]) resv_v = 0;
    exp_wr.push_back(wr_t'{addr: w, data: d, be: b});
    exp_st_cnt++;
  endtask

  task automatic ref_amo(input logic [3:0]  op,
                         input logic [1:0]  sz,
                         input logic [55:0] a,
                         input logic [63:0] opd);
    logic [15:0] w;
    logic [63:0] old, res, nv, wd, m;
    logic [31:0] o32, b32, n32;
    logic [7:0]  b;
    bit          word, hi, wr;
    w    = a[18:3];
    word = (sz == 2'b10);
    hi   = a[2];
    old  = ref_mem[w];
    o32  = hi ? old[63:32] : old[31:0];
    b32  = opd[31:0];
    res  = word ? {{32{o32[31]}}, o32} : old;
    wr   = 1;
    n32  = b32;
    nv   = opd;
    exp_amo_cnt++;
    case (op)
      4'h1: begin
        wr = 0;
        resv_v = 1;
        resv_a = a[55:3];
      end
      4'h2: begin
        wr = resv_v && (resv_a == a[55:3]);
        res = wr ? 64'd0 : 64'd1;
        resv_v = 0;
      end
      4'h3: ;
      4'h4: begin n32 = o32 + b32; nv = old + opd; end
      4'h5: begin n32 = o32 & b32; nv = old & opd; end
      4'h6: begin n32 = o32 | b32; nv = old | opd; end
      4'h7: begin n32 = o32 ^ b32; nv = old ^ opd; end
      4'h8: begin
        n32 = ($signed(o32) > $signed(b32)) ? o32 : b32;
        nv  = ($signed(old) > $signed(opd)) ? old : opd;
      end
      4'h9: begin
        n32 = (o32 > b32) ? o32 : b32;
        nv  = (old > opd) ? old : opd;
      end
      4'hA: begin
        n32 = ($signed(o32) < $signed(b32)) ? o32 : b32;
        nv  = ($signed(old) < $signed(opd)) ? old : opd;
      end
      4'hB: begin
        n32 = (o32 < b32) ? o32 : b32;
        nv  = (old < opd) ? old : opd;
      end
      default: begin wr = 0; res = 0; end
    endcase
    if (wr) begin
      if (word) begin
        b  = hi ? 8'hF0 : 8'h0F;
        wd = hi ? {n32, 32'h0} : {32'h0, n32};
      end else begin
        b  = 8'hFF;
        wd = nv;
      end
      m = bmask(b);
      ref_mem[w] = (ref_mem[w] & ~m) | (wd & m);
      exp_wr.push_back(wr_t'{addr: w, data: wd, be: b});
    end
    exp_res.push_back(res);
  endtask

  // Memory environment and write monitor
  initial begin
    mem_gnt    = 0;
    mem_rvalid = 0;
    mem_rdata  = 0;
    rv_cnt     = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      if (rst) begin
        rv_cnt  = 0;
        mem_gnt = 0;
        continue;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1;
          mem_rdata  = rd_pend;
        end
      end else if (!mem_req && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1;
        mem_rdata  = {$urandom, $urandom};
      end
      mem_gnt = mem_req && ($urandom_range(0, 2) != 0);
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_unexpected: addr %h data %h be %h",
                     mem_addr, mem_wdata, mem_be);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.addr));
            chk("wr_be", 64'(mem_be), 64'(e.be));
            chk("wr_data", mem_wdata & bmask(mem_be),
                e.data & bmask(e.be));
          end
          mem[mem_addr] = (mem[mem_addr] & ~bmask(mem_be)) |
                          (mem_wdata & bmask(mem_be));
        end else begin
          rd_pend = mem[mem_addr];
          rv_cnt  = $urandom_range(1, 3);
        end
      end
    end
  end

  // AMO response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && amo_ack) begin
        if (exp_res.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ack_unexpected: result %h", amo_result);
        end else begin
          chk("amo_result", amo_result, exp_res.pop_front());
        end
        last_res = amo_result;
      end
    end
  end

  task automatic clr_inputs();
    st_req = 0; st_index = 0; st_wdata = 0; st_be = 0;
    st_tag_valid = 0; st_tag = 0; st_kill = 0;
    amo_req = 0; amo_op = 0; amo_size = 0;
    amo_addr = 0; amo_operand = 0;
  endtask

  task automatic reset_pulse();
    rst = 1;
    clr_inputs();
    resv_v = 0;
    exp_st_cnt = 0;
    exp_amo_cnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic wait_wr_drain();
    int c = 0;
    while (exp_wr.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_wr.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wr_timeout: got %0d pending expected 0",
               exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic do_store(input logic [55:0] pa,
                          input logic [63:0] d,
                          input logic [7:0]  b,
                          input bit tv, input bit kill,
                          output int waited);
    st_req = 1; st_index = pa[11:0];
    st_wdata = d; st_be = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (st_gnt) break;
      waited++;
      if (waited > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL gnt_timeout: got 0 expected 1");
        st_req = 0;
        return;
      end
    end
    if (tv && !kill) ref_store(pa, d, b);
    @(posedge clk); #1;
    st_req = 0;
    st_tag_valid = tv;
    st_tag = pa[55:12];
    st_kill = kill;
    @(posedge clk); #1;
    st_tag_valid = 0;
    st_kill = 0;
    if (tv && !kill) wait_wr_drain();
  endtask

  task automatic wait_ack_release();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!amo_ack && c < 300);
    if (!amo_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    amo_req = 0;
  endtask

  task automatic do_amo(input logic [3:0]  op,
                        input logic [1:0]  sz,
                        input logic [55:0] a,
                        input logic [63:0] opd);
    ref_amo(op, sz, a, opd);
    amo_req = 1; amo_op = op; amo_size = sz;
    amo_addr = a; amo_operand = opd;
    wait_ack_release();
  endtask

  initial begin
    int waited;
    logic [55:0] pool [4];
    pool[0] = 56'h1000; pool[1] = 56'h1008;
    pool[2] = 56'h2000; pool[3] = 56'h2008;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    last_res = 0;
    rst = 1;
    clr_inputs();
    reset_pulse();
    @(negedge clk);
    chk("rst_gnt", 64'(st_gnt), 0);
    chk("rst_ack", 64'(amo_ack), 0);
    chk("rst_result", amo_result, 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 64'(mem_be), 0);
    chk("rst_perf_st", 64'(perf_st), 0);
    chk("rst_perf_amo", 64'(perf_amo), 0);
    @(posedge clk); #1;

    do_store(56'h1000, 64'h1122334455667788, 8'hFF,
             1, 0, waited);
    chk("store_mem", mem[16'h0200], 64'h1122334455667788);

    do_store(56'h1000, 64'hDEADBEEF00000000, 8'hFF,
             1, 1, waited);
    do_store(56'h1008, 64'h0123456789ABCDEF, 8'h3C,
             1, 0, waited);
    chk("gnt_after_kill", 64'(waited), 0);
    chk("kill_no_write", mem[16'h0200],
        64'h1122334455667788);

    set_mem(16'h0200, 64'h7FFFFFFF_00000000);
    do_amo(ADD, 2'b10, 56'h1004, 64'd1);
    chk("add_w_result", last_res, 64'h00000000_7FFFFFFF);
    chk("add_w_mem", mem[16'h0200], 64'h80000000_00000000);

    do_amo(LR, 2'b11, 56'h2000, 0);
    do_amo(SC, 2'b11, 56'h2000, 64'hCAFEF00D_12345678);
    chk("sc_ok_result", last_res, 0);
    chk("sc_ok_mem", mem[16'h0400], 64'hCAFEF00D_12345678);
    do_amo(LR, 2'b11, 56'h2000, 0);
    do_store(56'h2000, 64'h5555AAAA_5555AAAA, 8'hFF,
             1, 0, waited);
    do_amo(SC, 2'b11, 56'h2000, 64'h1);
    chk("sc_fail_result", last_res, 1);
    chk("sc_fail_mem", mem[16'h0400], 64'h5555AAAA_5555AAAA);

    set_mem(16'h0600, 64'h00000000_FFFFFFFF);
    do_amo(MIN, 2'b10, 56'h3000, 64'd1);
    chk("min_w_result", last_res, 64'hFFFFFFFF_FFFFFFFF);
    chk("min_w_mem", mem[16'h0600], 64'h00000000_FFFFFFFF);

    do_amo(4'h0, 2'b11, 56'h3000, 64'h77);
    chk("amo_none_result", last_res, 0);
    do_amo(SWAP, 2'b11, 56'h3008, 64'h42);
    do_amo(4'hC, 2'b11, 56'h3008, 64'h99);
    chk("amo_cas_result", last_res, 0);

    // Store and AMO requested together, AMO held past ack
    reset_pulse();
    ref_store(56'h2000, 64'hA5A5A5A5_0F0F0F0F, 8'hFF);
    ref_amo(SWAP, 2'b11, 56'h2008, 64'h600DF00D);
    st_req = 1; st_index = 12'h000;
    st_wdata = 64'hA5A5A5A5_0F0F0F0F; st_be = 8'hFF;
    amo_req = 1; amo_op = SWAP; amo_size = 2'b11;
    amo_addr = 56'h2008; amo_operand = 64'h600DF00D;
    @(negedge clk);
    chk("prio_st_gnt", 64'(st_gnt), 1);
    @(posedge clk); #1;
    st_req = 0; st_tag_valid = 1; st_tag = 44'h2;
    @(posedge clk); #1;
    st_tag_valid = 0;
    wait_ack_release();
    repeat (4) @(posedge clk);
    #1;
    chk("prio_wr_left", 64'(exp_wr.size()), 0);
`ifdef STRESP_PERF_CNT_EN
    chk("prio_perf_st", 64'(perf_st), 64'(exp_st_cnt));
    chk("prio_perf_amo", 64'(perf_amo), 64'(exp_amo_cnt));
`else
    chk("prio_perf_st", 64'(perf_st), 0);
    chk("prio_perf_amo", 64'(perf_amo), 0);
`endif

    for (int n = 0; n < 200; n++) begin
      logic [55:0] a;
      int r;
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) begin
        do_store(a, {$urandom, $urandom},
                 8'($urandom_range(1, 255)),
                 $urandom_range(0, 5) != 0,
                 $urandom_range(0, 4) == 0, waited);
      end else begin
        logic [3:0] op;
        logic [1:0] sz;
        r  = $urandom_range(0, 15);
        op = (r <= 13) ? 4'(r) : ((r == 14) ? LR : SC);
        sz = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        if (sz == 2'b10 && $urandom_range(0, 1) == 1)
          a = a + 56'd4;
        do_amo(op, sz, a, {$urandom, $urandom});
      end
    end

    // Reset in the middle of a store and after an LR
    do_amo(LR, 2'b11, 56'h1008, 0);
    st_req = 1; st_index = 12'h008;
    st_wdata = 64'hBAD0BAD0BAD0BAD0; st_be = 8'hFF;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(st_gnt), 1);
    @(posedge clk); #1;
    reset_pulse();
    @(negedge clk);
    chk("mid_rst_mem_req", 64'(mem_req), 0);
    @(posedge clk); #1;
    do_amo(SC, 2'b11, 56'h1008, 64'h1234);
    chk("sc_after_rst", last_res, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("end_wr_left", 64'(exp_wr.size()), 0);
    chk("end_res_left", 64'(exp_res.size()), 0);
    for (int i = 0; i < 4; i++)
      chk("end_mem", mem[pool[i][18:3]],
          ref_mem[pool[i][18:3]]);
`ifdef STRESP_PERF_CNT_EN
    chk("end_perf_st", 64'(perf_st), 64'(exp_st_cnt));
    chk("end_perf_amo", 64'(perf_amo), 64'(exp_amo_cnt));
`else
    chk("end_perf_st", 64'(perf_st), 0);
    chk("end_perf_amo", 64'(perf_amo), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
